sevenseg_scan: RTL

//  Drives the Nexys4 8-digit common-anode seven-segment display from a 32-bit hex value.
//  It time-multiplexes one digit per refresh slot and decodes each nibble to segments.
//  Per-digit decimal points and per-digit blanking are supported.
//  A load/shadow scheme applies updates only at frame boundaries, so a frame never mixes old and new values.
//  It sits in the output (user-display) path, the counterpart to the input debouncing path.

---
 rtl/sevenseg_scan.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan.sv
// Eight-digit common-anode seven-segment scanner with per-digit dp/blank and
// frame-aligned shadow loading so a frame never mixes old and new values.
module sevenseg_scan #(
   parameter int unsigned CLK_FREQUENCY_HZ       = 50_000_000,
   parameter int unsigned REFRESH_FREQUENCY_HZ   = 4000,
   parameter int unsigned BLANK_CYCLES           = 16,
   parameter int unsigned CNTR_WIDTH             = 32,
   parameter int unsigned SIMULATE               = 0,
   parameter int unsigned SIMULATE_FREQUENCY_CNT = 5
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] digits_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  blank_in,
   input  logic        load,
   output logic        pending,
   output logic        frame_tick,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int unsigned Top = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                                 : CLK_FREQUENCY_HZ / REFRESH_FREQUENCY_HZ - 1;
   localparam int unsigned Blk = (SIMULATE != 0) ? 1 : BLANK_CYCLES;
   localparam logic [CNTR_WIDTH-1:0] TopCnt = CNTR_WIDTH'(Top);
   localparam logic [CNTR_WIDTH-1:0] BlkCnt = CNTR_WIDTH'(Blk);

   logic [CNTR_WIDTH-1:0] slot_cnt_q, slot_cnt_d;
   logic [2:0]            digit_idx_q, digit_idx_d;
   logic                  frame_tick_q, frame_tick_d;
   logic                  pending_q, pending_d;
   logic [31:0]           act_dig_q, act_dig_d, sh_dig_q, sh_dig_d;
   logic [7:0]            act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
   logic [7:0]            act_blank_q, act_blank_d, sh_blank_q, sh_blank_d;
   logic [7:0]            an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;

   logic       slot_at_top;
   logic       boundary;
   logic       dark;
   logic [3:0] nibble;
   logic [6:0] hex;

   always_comb begin
      slot_at_top  = (slot_cnt_q == TopCnt);
      boundary     = slot_at_top && (digit_idx_q == 3'd7);
      slot_cnt_d   = slot_at_top ? '0 : slot_cnt_q + 1'b1;
      digit_idx_d  = slot_at_top ? digit_idx_q + 3'd1 : digit_idx_q;
      frame_tick_d = boundary;
   end

   // A load coinciding with the boundary bypasses the shadow entirely.
   always_comb begin
      act_dig_d   = act_dig_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      sh_dig_d    = sh_dig_q;
      sh_dp_d     = sh_dp_q;
      sh_blank_d  = sh_blank_q;
      pending_d   = pending_q;
      if (load && boundary) begin
         act_dig_d   = digits_in;
         act_dp_d    = dp_in;
         act_blank_d = blank_in;
         pending_d   = 1'b0;
      end else if (load) begin
         sh_dig_d   = digits_in;
         sh_dp_d    = dp_in;
         sh_blank_d = blank_in;
         pending_d  = 1'b1;
      end else if (boundary && pending_q) begin
         act_dig_d   = sh_dig_q;
         act_dp_d    = sh_dp_q;
         act_blank_d = sh_blank_q;
         pending_d   = 1'b0;
      end
   end

   always_comb begin
      nibble = act_dig_q[{digit_idx_q, 2'b00} +: 4];
      case (nibble)
         4'h0: hex = 7'h3F;
         4'h1: hex = 7'h06;
         4'h2: hex = 7'h5B;
         4'h3: hex = 7'h4F;
         4'h4: hex = 7'h66;
         4'h5: hex = 7'h6D;
         4'h6: hex = 7'h7D;
         4'h7: hex = 7'h07;
         4'h8: hex = 7'h7F;
         4'h9: hex = 7'h6F;
         4'hA: hex = 7'h77;
         4'hB: hex = 7'h7C;
         4'hC: hex = 7'h39;
         4'hD: hex = 7'h5E;
         4'hE: hex = 7'h79;
         default: hex = 7'h71;
      endcase
      // Leading blank cycles of each slot keep the anode off while cathodes settle.
      dark = (slot_cnt_q < BlkCnt) || act_blank_q[digit_idx_q];
      an_d  = dark ? 8'hFF : ~(8'h01 << digit_idx_q);
      seg_d = dark ? 7'h7F : ~hex;
      dp_d  = dark ? 1'b1 : ~act_dp_q[digit_idx_q];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         slot_cnt_q   <= '0;
         digit_idx_q  <= 3'd0;
         frame_tick_q <= 1'b0;
         pending_q    <= 1'b0;
         act_dig_q    <= 32'h0;
         act_dp_q     <= 8'h00;
         act_blank_q  <= 8'hFF;
         sh_dig_q     <= 32'h0;
         sh_dp_q      <= 8'h00;
         sh_blank_q   <= 8'hFF;
         an_q         <= 8'hFF;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
      end else begin
         slot_cnt_q   <= slot_cnt_d;
         digit_idx_q  <= digit_idx_d;
         frame_tick_q <= frame_tick_d;
         pending_q    <= pending_d;
         act_dig_q    <= act_dig_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         sh_dig_q     <= sh_dig_d;
         sh_dp_q      <= sh_dp_d;
         sh_blank_q   <= sh_blank_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign pending    = pending_q;
   assign frame_tick = frame_tick_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;

endmodule
